// File: rtl/truth_table_sequencer_if.sv
// Handshake and result bundle between a host, the truth-table sequencer and
// the combinational block under exercise.
interface truth_table_sequencer_if #(
    parameter int N_INPUTS = 3
);
    localparam int VEC = 1 << N_INPUTS;

    logic                start;
    logic [VEC-1:0]      expected_tt;
    logic [N_INPUTS-1:0] dut_in;
    logic                dut_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [VEC-1:0]      captured_tt;
    logic [N_INPUTS:0]   fail_count;
    logic [N_INPUTS-1:0] first_fail_idx;

    // master: host side (also sources dut_out from the block); slave: sequencer
    modport master (
        output start, expected_tt, dut_out,
        input  dut_in, busy, done, pass, captured_tt, fail_count, first_fail_idx
    );

    modport slave (
        input  start, expected_tt, dut_out,
        output dut_in, busy, done, pass, captured_tt, fail_count, first_fail_idx
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of an N-input combinational block, holds each for
// SETTLE_CYCLES, samples F and scores it against an expected truth table.
module truth_table_sequencer #(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    truth_table_sequencer_if.slave  bus
);
    localparam int VEC   = 1 << N_INPUTS;
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]    CNT_LOAD = SETTLE_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_INPUTS:0]   FAIL_MAX = VEC[N_INPUTS:0];
    localparam logic [N_INPUTS-1:0] LAST_IDX = {N_INPUTS{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt_q;
    logic [VEC-1:0]      exp_q;
    logic [N_INPUTS-1:0] dut_in_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [VEC-1:0]      cap_q;
    logic [N_INPUTS:0]   fail_q;
    logic [N_INPUTS-1:0] first_q;

    logic mismatch;
    logic last_vec;

    // Saturating increment; the count is bounded by VEC so this never clips
    // in practice, but it keeps the counter well-defined if parameters change.
    function automatic logic [N_INPUTS:0] fail_inc(input logic [N_INPUTS:0] c);
        return (c == FAIL_MAX) ? c : c + 1'b1;
    endfunction

    assign mismatch = (bus.dut_out != exp_q[dut_in_q]);
    assign last_vec = (dut_in_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt_q    <= '0;
            exp_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cap_q    <= '0;
            fail_q   <= '0;
            first_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        exp_q    <= bus.expected_tt;
                        dut_in_q <= '0;
                        cap_q    <= '0;
                        fail_q   <= '0;
                        first_q  <= '0;
                        pass_q   <= 1'b0;
                        cnt_q    <= CNT_LOAD;
                        busy_q   <= 1'b1;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    cap_q[dut_in_q] <= bus.dut_out;
                    if (mismatch) begin
                        fail_q <= fail_inc(fail_q);
                        if (fail_q == '0) begin
                            first_q <= dut_in_q;
                        end
                    end
                    // pass must already reflect this final sample in the done cycle
                    if (last_vec) begin
                        done_q <= 1'b1;
                        pass_q <= (fail_q == '0) && !mismatch;
                        state  <= S_DONE;
                    end else begin
                        dut_in_q <= dut_in_q + 1'b1;
                        cnt_q    <= CNT_LOAD;
                        state    <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in         = dut_in_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.captured_tt    = cap_q;
    assign bus.fail_count     = fail_q;
    assign bus.first_fail_idx = first_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed and randomized sweeps of truth_table_sequencer, scored against a
// truth-table reference model built from XOR/popcount over whole tables.
module tb_truth_table_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] block_tt;
    int n_total = 0;
    int n_pass  = 0;

    truth_table_sequencer_if #(.N_INPUTS(3)) bus ();

    truth_table_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // The combinational block under exercise: any 3-input function given as a table.
    assign bus.dut_out = block_tt[bus.dut_in];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Full sweep from IDLE; cycle k = k-th cycle after the accepting edge.
    task automatic run_sweep(input string tag, input logic [7:0] blk,
                             input logic [7:0] exp_tt, input bit repulse);
        logic [7:0] diff;
        int m_fail, m_first;
        int busy_first, busy_cnt, done_cnt, done_at, seq_err;
        logic pass_at_done;
        logic [3:0] fail_at_done;

        diff = blk ^ exp_tt;
        m_fail = $countones(diff);
        m_first = 0;
        for (int i = 7; i >= 0; i--) if (diff[i]) m_first = i;

        busy_first = -1; busy_cnt = 0; done_cnt = 0; done_at = -1; seq_err = 0;
        pass_at_done = 1'bx; fail_at_done = 'x;

        block_tt = blk;
        bus.expected_tt = exp_tt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.expected_tt = ~exp_tt;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin
                check({tag, ":cleared_cap"}, 32'(bus.captured_tt), 32'h0);
                check({tag, ":cleared_fail"}, 32'(bus.fail_count), 32'h0);
            end
            if (bus.busy) begin
                if (busy_first < 0) busy_first = k;
                busy_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                done_at = k;
                pass_at_done = bus.pass;
                fail_at_done = bus.fail_count;
            end
            if (k <= 24 && bus.dut_in !== 3'((k - 1) / 3)) seq_err++;
            if (repulse && k == 10) begin
                bus.start = 1'b1;
                bus.expected_tt = 8'($urandom);
            end
            if (repulse && k == 11) bus.start = 1'b0;
        end
        check({tag, ":done_at"}, 32'(done_at), 32'd25);
        check({tag, ":done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, ":busy_first"}, 32'(busy_first), 32'd1);
        check({tag, ":busy_cnt"}, 32'(busy_cnt), 32'd25);
        check({tag, ":dut_in_seq"}, 32'(seq_err), 32'd0);
        check({tag, ":pass_at_done"}, 32'(pass_at_done), 32'(m_fail == 0));
        check({tag, ":fail_at_done"}, 32'(fail_at_done), 32'(m_fail));
        check({tag, ":captured_tt"}, 32'(bus.captured_tt), 32'(blk));
        check({tag, ":fail_count"}, 32'(bus.fail_count), 32'(m_fail));
        check({tag, ":first_fail"}, 32'(bus.first_fail_idx), 32'(m_first));
        check({tag, ":pass_hold"}, 32'(bus.pass), 32'(m_fail == 0));
        check({tag, ":dut_in_hold"}, 32'(bus.dut_in), 32'd7);
    endtask

    initial begin
        int d_cnt, d_first, d_second, b26, b27;
        logic [7:0] rb, rm;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.expected_tt = 8'h00;
        block_tt = 8'h96;
        repeat (2) @(negedge clk);
        check("rst:dut_in", 32'(bus.dut_in), 32'd0);
        check("rst:busy", 32'(bus.busy), 32'd0);
        check("rst:done", 32'(bus.done), 32'd0);
        check("rst:pass", 32'(bus.pass), 32'd0);
        check("rst:captured", 32'(bus.captured_tt), 32'd0);
        check("rst:fail", 32'(bus.fail_count), 32'd0);
        check("rst:first", 32'(bus.first_fail_idx), 32'd0);
        reset = 1'b0;

        run_sweep("xor_ok", 8'h96, 8'h96, 1'b0);
        run_sweep("xor_exp97", 8'h96, 8'h97, 1'b0);
        run_sweep("xor_exp69", 8'h96, 8'h69, 1'b0);
        run_sweep("bit5", 8'h96 | 8'h20, 8'h96 & 8'hDF, 1'b0);
        run_sweep("repulse", 8'h3C, 8'h38, 1'b1);
        run_sweep("after_repulse", 8'hA5, 8'hA5, 1'b0);

        // Reset in the middle of vector 3 (cycles 10..12) after a vector-0 mismatch.
        block_tt = 8'h96;
        bus.expected_tt = 8'h97;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst:pre_fail", 32'(bus.fail_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst:busy", 32'(bus.busy), 32'd0);
        check("midrst:dut_in", 32'(bus.dut_in), 32'd0);
        check("midrst:fail", 32'(bus.fail_count), 32'd0);
        check("midrst:captured", 32'(bus.captured_tt), 32'd0);
        d_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) d_cnt++;
        end
        check("midrst:no_activity", 32'(d_cnt), 32'd0);
        run_sweep("post_rst", 8'h96, 8'h96, 1'b0);

        // start held high: second sweep begins in the first IDLE cycle after done.
        block_tt = 8'h96;
        bus.expected_tt = 8'h96;
        @(negedge clk);
        bus.start = 1'b1;
        d_cnt = 0; d_first = -1; d_second = -1; b26 = -1; b27 = -1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (bus.done) begin
                d_cnt++;
                if (d_first < 0) d_first = k; else d_second = k;
            end
            if (k == 26) b26 = int'(bus.busy);
            if (k == 27) begin
                b27 = int'(bus.busy);
                bus.start = 1'b0;
            end
        end
        check("hold:first_done", 32'(d_first), 32'd25);
        check("hold:idle_gap", 32'(b26), 32'd0);
        check("hold:restart", 32'(b27), 32'd1);
        check("hold:second_done", 32'(d_second), 32'd51);
        check("hold:done_cnt", 32'(d_cnt), 32'd2);

        for (int r = 0; r < 5; r++) begin
            rb = 8'($urandom);
            rm = (r == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
            run_sweep($sformatf("rand%0d", r), rb, rb ^ rm, r[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
